// File: rtl/sid_wb_arb_if.sv
// Signal bundle between the write-back arbiter and its EX, SID and data-bus neighbours.
// The slave modport is the arbiter's view; the master modport drives it.
interface sid_wb_arb_if;
    logic        ex_req_i;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_data_i;
    logic [31:0] ex_rdata_o;
    logic        sid_valid_i;
    logic [31:0] sid_addr_i;
    logic [31:0] sid_data_i;
    logic        sid_ready_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_rdata_i;
    logic        bus_hold_i;
    logic        hold_flag_o;

    modport slave (
        input  ex_req_i, ex_we_i, ex_addr_i, ex_data_i,
        input  sid_valid_i, sid_addr_i, sid_data_i,
        input  bus_rdata_i, bus_hold_i,
        output ex_rdata_o, sid_ready_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_data_o,
        output hold_flag_o
    );

    modport master (
        output ex_req_i, ex_we_i, ex_addr_i, ex_data_i,
        output sid_valid_i, sid_addr_i, sid_data_i,
        output bus_rdata_i, bus_hold_i,
        input  ex_rdata_o, sid_ready_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_data_o,
        input  hold_flag_o
    );
endinterface

// File: rtl/sid_wb_arb.sv
// Shares the core data-bus master port between EX and buffered SID result writes.
// EX wins by default; SID writes drain on idle cycles, on starvation or on an address hazard.
module sid_wb_arb #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    sid_wb_arb_if.slave    arb
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [31:0]   addr_mem_r [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [SW-1:0] starve_cnt_r;

    logic empty_s;
    logic ready_s;
    logic push_s;
    logic hazard_s;
    logic starve_s;
    logic grant_fifo_s;

    assign empty_s      = (count_r == {(AW+1){1'b0}});
    assign ready_s      = (count_r != DEPTH_C);
    assign push_s       = arb.sid_valid_i && ready_s;
    assign starve_s     = (starve_cnt_r == STARVE_C);
    assign grant_fifo_s = !empty_s && !arb.bus_hold_i && (!arb.ex_req_i || starve_s || hazard_s);

    // Word-address match of the EX request against every occupied FIFO entry.
    always_comb begin
        logic match_any_s;
        match_any_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_any_s = match_any_s |
                (valid_r[i] && (addr_mem_r[i][31:2] == arb.ex_addr_i[31:2]));
        end
        hazard_s = arb.ex_req_i && !empty_s && match_any_s;
    end

    // Bus steering: the FIFO head when granted, otherwise EX passes straight through.
    always_comb begin
        arb.bus_req_o  = arb.ex_req_i;
        arb.bus_we_o   = arb.ex_we_i;
        arb.bus_addr_o = arb.ex_addr_i;
        arb.bus_data_o = arb.ex_data_i;
        if (grant_fifo_s) begin
            arb.bus_req_o  = 1'b1;
            arb.bus_we_o   = 1'b1;
            arb.bus_addr_o = addr_mem_r[rd_ptr_r];
            arb.bus_data_o = data_mem_r[rd_ptr_r];
        end else begin
            arb.bus_req_o  = arb.ex_req_i;
            arb.bus_we_o   = arb.ex_we_i;
            arb.bus_addr_o = arb.ex_addr_i;
            arb.bus_data_o = arb.ex_data_i;
        end
    end

    assign arb.ex_rdata_o  = arb.bus_rdata_i;
    assign arb.sid_ready_o = ready_s;
    // Hold also covers a hazard while the bus is held, so EX never overtakes a pending write.
    assign arb.hold_flag_o = arb.ex_req_i && (grant_fifo_s || hazard_s);

    // FIFO storage and occupancy flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= 32'h0000_0000;
                data_mem_r[i] <= 32'h0000_0000;
            end
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (grant_fifo_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
            end
            if (push_s) begin
                addr_mem_r[wr_ptr_r] <= arb.sid_addr_i;
                data_mem_r[wr_ptr_r] <= arb.sid_data_i;
                valid_r[wr_ptr_r]    <= 1'b1;
            end
        end
    end

    // Pointers and occupancy count; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (grant_fifo_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, grant_fifo_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: counts EX-owned cycles while SID work waits, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_fifo_s || empty_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (arb.ex_req_i && !arb.bus_hold_i && !starve_s) begin
            starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
endmodule

// File: tb/tb_sid_wb_arb.sv
// Scoreboard bench for sid_wb_arb: directed stimulus queues expected bus cycles,
// a negedge monitor pops and compares whenever the arbiter requests the bus.
module tb_sid_wb_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sid_wb_arb_if bif ();

    sid_wb_arb #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bif)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        hold;
    } txn_t;

    txn_t exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic drv(input logic er, input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
                       input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic bh);
        bif.ex_req_i    = er;
        bif.ex_we_i     = ewe;
        bif.ex_addr_i   = ea;
        bif.ex_data_i   = ed;
        bif.sid_valid_i = sv;
        bif.sid_addr_i  = sa;
        bif.sid_data_i  = sd;
        bif.bus_hold_i  = bh;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic expect_bus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic h);
        txn_t t;
        t = '{we: we, addr: a, data: d, hold: h};
        exp_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every bus request must match the next queued expectation.
    always @(negedge clk) begin
        txn_t got;
        txn_t want;
        if (rst && bif.bus_req_o) begin
            got = '{we: bif.bus_we_o, addr: bif.bus_addr_o, data: bif.bus_data_o, hold: bif.hold_flag_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bus_cycle: got we=%0b addr=%h data=%h hold=%0b expected no request",
                         got.we, got.addr, got.data, got.hold);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL bus_cycle: got we=%0b addr=%h data=%h hold=%0b expected we=%0b addr=%h data=%h hold=%0b",
                             got.we, got.addr, got.data, got.hold, want.we, want.addr, want.data, want.hold);
                end
            end
        end
    end

    initial begin
        idle();
        bif.bus_rdata_i = 32'hCAFE_F00D;
        tick();
        tick();
        #1;
        chk("rst_sid_ready", {31'd0, bif.sid_ready_o}, 32'd1);
        chk("rst_hold_flag", {31'd0, bif.hold_flag_o}, 32'd0);
        chk("rst_ex_rdata", bif.ex_rdata_o, 32'hCAFE_F00D);
        chk("rst_count", 32'(dut.count_r), 32'd0);
        chk("rst_starve_cnt", 32'(dut.starve_cnt_r), 32'd0);
        rst = 1'b1;
        tick();

        // Pass-through EX read
        drv(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_bus(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        #1;
        chk("pass_bus_addr", bif.bus_addr_o, 32'h0000_1000);
        chk("pass_sid_ready", {31'd0, bif.sid_ready_o}, 32'd1);
        tick();

        // Fill to full under unrelated EX writes, then drain with a held 5th push
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b1, 32'h5000 + 32'(4*i), 32'h5550 + 32'(i),
                1'b1, 32'h2000 + 32'(4*i), 32'h100 + 32'(i), 1'b0);
            expect_bus(1'b1, 32'h5000 + 32'(4*i), 32'h5550 + 32'(i), 1'b0);
            #1;
            chk("fill_sid_ready", {31'd0, bif.sid_ready_o}, 32'd1);
            tick();
        end
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2010, 32'h104, 1'b0);
        expect_bus(1'b1, 32'h2000, 32'h100, 1'b0);
        #1;
        chk("full_sid_ready", {31'd0, bif.sid_ready_o}, 32'd0);
        tick();
        expect_bus(1'b1, 32'h2004, 32'h101, 1'b0);
        #1;
        chk("after_pop_sid_ready", {31'd0, bif.sid_ready_o}, 32'd1);
        tick();
        idle();
        expect_bus(1'b1, 32'h2008, 32'h102, 1'b0);
        tick();
        expect_bus(1'b1, 32'h200C, 32'h103, 1'b0);
        tick();
        expect_bus(1'b1, 32'h2010, 32'h104, 1'b0);
        tick();
        chk("drain_count", 32'(dut.count_r), 32'd0);

        // Starvation: one queued entry against a continuous EX stream
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h6000, 32'hAAAA, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
            expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
            tick();
        end
        chk("starve_cnt_sat", 32'(dut.starve_cnt_r), 32'd8);
        expect_bus(1'b1, 32'h6000, 32'hAAAA, 1'b1);
        tick();
        chk("starve_cnt_clear", 32'(dut.starve_cnt_r), 32'd0);
        expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
        tick();
        idle();
        tick();

        // RAW hazard drains both entries in order before the EX read issues
        drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b1, 32'h3004, 32'hDEAD, 1'b0);
        expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b1, 32'h3008, 32'hBEEF, 1'b0);
        expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 32'h3008, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_bus(1'b1, 32'h3004, 32'hDEAD, 1'b1);
        tick();
        expect_bus(1'b1, 32'h3008, 32'hBEEF, 1'b1);
        tick();
        expect_bus(1'b0, 32'h3008, 32'h0, 1'b0);
        bif.bus_rdata_i = 32'h1234_5678;
        #1;
        chk("raw_ex_rdata", bif.ex_rdata_o, 32'h1234_5678);
        tick();
        idle();
        tick();

        // Bus hold freezes the FIFO and the starvation counter
        drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b1, 32'h4000, 32'h4444, 1'b0);
        expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
            expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
            tick();
        end
        chk("hold_starve_frozen", 32'(dut.starve_cnt_r), 32'd1);
        chk("hold_count_frozen", 32'(dut.count_r), 32'd1);
        idle();
        expect_bus(1'b1, 32'h4000, 32'h4444, 1'b0);
        tick();
        chk("hold_resume_count", 32'(dut.count_r), 32'd0);

        // Reset in the middle of a partially filled FIFO
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, 32'h7000, 32'h0, 1'b1, 32'h8000 + 32'(4*i), 32'h800 + 32'(i), 1'b0);
            expect_bus(1'b0, 32'h7000, 32'h0, 1'b0);
            tick();
        end
        chk("prereset_count", 32'(dut.count_r), 32'd3);
        idle();
        rst = 1'b0;
        #1;
        chk("midrst_count", 32'(dut.count_r), 32'd0);
        chk("midrst_sid_ready", {31'd0, bif.sid_ready_o}, 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
